// File: rtl/accelerator_pkg.sv
// Shared types and constants for the accelerator matrix loaders.
// Imported by the index counter and the stream loader.
package accelerator_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        HOLD,
        DONE
    } loader_state_e;

    localparam logic [63:0] ZERO_DATA    = 64'd0;
    localparam logic [63:0] ONE_DATA     = 64'd1;
    localparam logic [63:0] ZERO_CONTROL = 64'd0;
    localparam logic [63:0] ONE_CONTROL  = 64'd1;

endpackage

// File: rtl/accelerator_index_counter.sv
// 2-D (i, j) element counter with an incremental row-base accumulator.
// Shared by the W/K/U matrix loaders.
module accelerator_index_counter
    import accelerator_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    adv_j_i,
    input  logic                    adv_i_i,
    input  logic [DATA_SIZE-1:0]    size_i_i,
    input  logic [DATA_SIZE-1:0]    size_j_i,
    output logic [CONTROL_SIZE-1:0] j_o,
    output logic [DATA_SIZE-1:0]    row_base_o,
    output logic                    last_j_o,
    output logic                    last_i_o
);

    localparam logic [DATA_SIZE-1:0]    D_ZERO = DATA_SIZE'(ZERO_DATA);
    localparam logic [DATA_SIZE-1:0]    D_ONE  = DATA_SIZE'(ONE_DATA);
    localparam logic [CONTROL_SIZE-1:0] C_ZERO = CONTROL_SIZE'(ZERO_CONTROL);
    localparam logic [CONTROL_SIZE-1:0] C_ONE  = CONTROL_SIZE'(ONE_CONTROL);

    logic [CONTROL_SIZE-1:0] i_q;
    logic [CONTROL_SIZE-1:0] j_q;
    logic [DATA_SIZE-1:0]    row_base_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            i_q        <= C_ZERO;
            j_q        <= C_ZERO;
            row_base_q <= D_ZERO;
        end else if (adv_i_i) begin
            i_q        <= i_q + C_ONE;
            j_q        <= C_ZERO;
            row_base_q <= row_base_q + size_j_i;
        end else if (adv_j_i) begin
            j_q <= j_q + C_ONE;
        end
    end

    assign j_o        = j_q;
    assign row_base_o = row_base_q;
    assign last_j_o   = (j_q == CONTROL_SIZE'(size_j_i - D_ONE));
    assign last_i_o   = (i_q == CONTROL_SIZE'(size_i_i - D_ONE));

endmodule

// File: rtl/accelerator_matrix_stream_loader.sv
// Streams a row-major matrix from 1-cycle-latency memory into the
// controller's row/element strobe interface, paced by consumer requests.
module accelerator_matrix_stream_loader
    import accelerator_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic [DATA_SIZE-1:0] SIZE_I_IN,
    input  logic [DATA_SIZE-1:0] SIZE_J_IN,
    input  logic [DATA_SIZE-1:0] BASE_ADDR_IN,
    output logic [DATA_SIZE-1:0] MEM_ADDR,
    output logic                 MEM_RE,
    input  logic [DATA_SIZE-1:0] MEM_DATA,
    output logic [DATA_SIZE-1:0] DATA_OUT,
    output logic                 DATA_I_ENABLE,
    output logic                 DATA_J_ENABLE,
    input  logic                 REQ_I_ENABLE,
    input  logic                 REQ_J_ENABLE
);

    localparam logic [DATA_SIZE-1:0]    D_ZERO = DATA_SIZE'(ZERO_DATA);
    localparam logic [DATA_SIZE-1:0]    D_ONE  = DATA_SIZE'(ONE_DATA);
    localparam logic [CONTROL_SIZE-1:0] C_ZERO = CONTROL_SIZE'(ZERO_CONTROL);

    loader_state_e state_q;

    logic [DATA_SIZE-1:0] size_i_q;
    logic [DATA_SIZE-1:0] size_j_q;
    logic [DATA_SIZE-1:0] base_q;
    logic [DATA_SIZE-1:0] mem_addr_q;
    logic                 mem_re_q;
    logic [DATA_SIZE-1:0] data_q;
    logic                 i_en_q;
    logic                 j_en_q;
    logic                 ready_q;

    logic [CONTROL_SIZE-1:0] j;
    logic [DATA_SIZE-1:0]    row_base;
    logic                    last_j;
    logic                    last_i;

    logic                 clear;
    logic                 adv_j;
    logic                 adv_i;
    logic                 finish;
    logic [DATA_SIZE-1:0] addr_j_d;
    logic [DATA_SIZE-1:0] addr_i_d;

    always_comb begin
        clear    = (state_q == IDLE) && START;
        adv_j    = (state_q == HOLD) && !last_j && REQ_J_ENABLE;
        adv_i    = (state_q == HOLD) && last_j && !last_i && REQ_I_ENABLE;
        finish   = (state_q == HOLD) && last_j && last_i && REQ_I_ENABLE;
        addr_j_d = base_q + row_base + DATA_SIZE'(j) + D_ONE;
        addr_i_d = base_q + row_base + size_j_q;
    end

    accelerator_index_counter #(
        .DATA_SIZE   (DATA_SIZE),
        .CONTROL_SIZE(CONTROL_SIZE)
    ) u_index (
        .clk_i     (CLK),
        .rst_i     (RST),
        .clear_i   (clear),
        .adv_j_i   (adv_j),
        .adv_i_i   (adv_i),
        .size_i_i  (size_i_q),
        .size_j_i  (size_j_q),
        .j_o       (j),
        .row_base_o(row_base),
        .last_j_o  (last_j),
        .last_i_o  (last_i)
    );

    // Read address is issued one edge early so MEM_RE and MEM_ADDR are registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            size_i_q   <= D_ZERO;
            size_j_q   <= D_ZERO;
            base_q     <= D_ZERO;
            mem_addr_q <= D_ZERO;
            mem_re_q   <= 1'b0;
            data_q     <= D_ZERO;
            i_en_q     <= 1'b0;
            j_en_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            mem_re_q   <= 1'b0;
            mem_addr_q <= D_ZERO;
            ready_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (START) begin
                        size_i_q <= SIZE_I_IN;
                        size_j_q <= SIZE_J_IN;
                        base_q   <= BASE_ADDR_IN;
                        if (SIZE_I_IN == D_ZERO || SIZE_J_IN == D_ZERO) begin
                            state_q <= DONE;
                            ready_q <= 1'b1;
                        end else begin
                            state_q    <= FETCH;
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= BASE_ADDR_IN;
                        end
                    end
                end
                FETCH: begin
                    state_q <= LATCH;
                end
                LATCH: begin
                    data_q  <= MEM_DATA;
                    j_en_q  <= 1'b1;
                    i_en_q  <= (j == C_ZERO);
                    state_q <= HOLD;
                end
                HOLD: begin
                    j_en_q <= 1'b0;
                    i_en_q <= 1'b0;
                    if (adv_j) begin
                        state_q    <= FETCH;
                        mem_re_q   <= 1'b1;
                        mem_addr_q <= addr_j_d;
                    end else if (adv_i) begin
                        state_q    <= FETCH;
                        mem_re_q   <= 1'b1;
                        mem_addr_q <= addr_i_d;
                    end else if (finish) begin
                        state_q <= DONE;
                        ready_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign READY         = ready_q;
    assign MEM_ADDR      = mem_addr_q;
    assign MEM_RE        = mem_re_q;
    assign DATA_OUT      = data_q;
    assign DATA_I_ENABLE = i_en_q;
    assign DATA_J_ENABLE = j_en_q;

endmodule

// File: tb/tb_accelerator_matrix_stream_loader.sv
// Randomised scoreboard bench for the matrix stream loader.
// A plain row-major model feeds expected queues; a monitor checks outputs.
module tb_accelerator_matrix_stream_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        READY;
    logic [63:0] SIZE_I_IN = '0;
    logic [63:0] SIZE_J_IN = '0;
    logic [63:0] BASE_ADDR_IN = '0;
    logic [63:0] MEM_ADDR;
    logic        MEM_RE;
    logic [63:0] MEM_DATA = '0;
    logic [63:0] DATA_OUT;
    logic        DATA_I_ENABLE;
    logic        DATA_J_ENABLE;
    logic        REQ_I_ENABLE = 1'b0;
    logic        REQ_J_ENABLE = 1'b0;

    accelerator_matrix_stream_loader #(
        .DATA_SIZE(64),
        .CONTROL_SIZE(64)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .START(START),
        .READY(READY),
        .SIZE_I_IN(SIZE_I_IN),
        .SIZE_J_IN(SIZE_J_IN),
        .BASE_ADDR_IN(BASE_ADDR_IN),
        .MEM_ADDR(MEM_ADDR),
        .MEM_RE(MEM_RE),
        .MEM_DATA(MEM_DATA),
        .DATA_OUT(DATA_OUT),
        .DATA_I_ENABLE(DATA_I_ENABLE),
        .DATA_J_ENABLE(DATA_J_ENABLE),
        .REQ_I_ENABLE(REQ_I_ENABLE),
        .REQ_J_ENABLE(REQ_J_ENABLE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passes = 0;

    logic [63:0] exp_addr[$];
    logic [63:0] exp_data[$];
    logic        exp_ien[$];
    int          ready_exp = 0;

    logic        rst_d = 1'b1;
    logic        prev_j = 1'b0;
    logic [63:0] last_data = '0;

    function automatic logic [63:0] memv(input logic [63:0] a);
        if (a >= 64'h100 && a < 64'h106) return a - 64'd246;
        return (a * 64'h9E3779B97F4A7C15) ^ 64'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    // 1-cycle-latency synchronous memory
    always @(posedge CLK) begin
        if (MEM_RE) MEM_DATA <= memv(MEM_ADDR);
        rst_d <= RST;
    end

    always @(negedge CLK) begin
        if (rst_d) begin
            last_data = '0;
            prev_j = 1'b0;
        end else begin
            if (MEM_RE) begin
                if (exp_addr.size() == 0) chk("mem_re unexpected", MEM_RE, 0);
                else chk("mem_addr", MEM_ADDR, exp_addr.pop_front());
            end else begin
                chk("mem_addr idle", MEM_ADDR, 0);
            end
            if (DATA_J_ENABLE) begin
                chk("strobe pulse", prev_j, 0);
                if (exp_data.size() == 0) begin
                    chk("strobe unexpected", DATA_J_ENABLE, 0);
                end else begin
                    chk("data_out", DATA_OUT, exp_data.pop_front());
                    chk("i_enable", DATA_I_ENABLE, exp_ien.pop_front());
                end
                last_data = DATA_OUT;
            end else begin
                chk("i_enable alone", DATA_I_ENABLE, 0);
                chk("data hold", DATA_OUT, last_data);
            end
            if (READY) begin
                if (ready_exp == 0) chk("ready unexpected", READY, 0);
                else ready_exp--;
            end
            prev_j = DATA_J_ENABLE;
        end
    end

    task automatic run(input logic [63:0] si, input logic [63:0] sj,
                       input logic [63:0] base, input int smin,
                       input int smax, input bit wrong, input bit noise,
                       input int rst_at);
        logic [63:0] a;
        int n, k, cnt, c, r;
        for (int ri = 0; ri < int'(si); ri++) begin
            for (int ci = 0; ci < int'(sj); ci++) begin
                a = base + 64'(ri) * sj + 64'(ci);
                exp_addr.push_back(a);
                exp_data.push_back(memv(a));
                exp_ien.push_back(ci == 0);
            end
        end
        ready_exp++;
        @(negedge CLK);
        START = 1'b1;
        SIZE_I_IN = si;
        SIZE_J_IN = sj;
        BASE_ADDR_IN = base;
        @(negedge CLK);
        START = 1'b0;
        SIZE_I_IN = {$urandom, $urandom};
        SIZE_J_IN = {$urandom, $urandom};
        BASE_ADDR_IN = {$urandom, $urandom};
        if (si == 0 || sj == 0) begin
            chk("zero-size ready", READY, 1);
            return;
        end
        cnt = 1;
        n = int'(si) * int'(sj);
        for (int e = 0; e < n; e++) begin
            while (!DATA_J_ENABLE && cnt < 20) begin
                @(negedge CLK);
                cnt++;
            end
            chk("strobe latency", cnt, 3);
            if (!DATA_J_ENABLE) return;
            if (e == rst_at) begin
                RST = 1'b1;
                @(negedge CLK);
                RST = 1'b0;
                chk("rst ready", READY, 0);
                chk("rst mem_re", MEM_RE, 0);
                chk("rst mem_addr", MEM_ADDR, 0);
                chk("rst data_out", DATA_OUT, 0);
                chk("rst i_en", DATA_I_ENABLE, 0);
                chk("rst j_en", DATA_J_ENABLE, 0);
                exp_addr.delete();
                exp_data.delete();
                exp_ien.delete();
                ready_exp--;
                return;
            end
            c = e % int'(sj);
            r = e / int'(sj);
            k = $urandom_range(smax, smin);
            if ((wrong || noise) && k < 2) k = 2;
            for (int s = 0; s < k; s++) begin
                if (wrong && s == 0) begin
                    if (c == int'(sj) - 1) REQ_J_ENABLE = 1'b1;
                    else REQ_I_ENABLE = 1'b1;
                end
                if (noise && s == 1) START = 1'b1;
                @(negedge CLK);
                REQ_I_ENABLE = 1'b0;
                REQ_J_ENABLE = 1'b0;
                START = 1'b0;
            end
            if (c == int'(sj) - 1) REQ_I_ENABLE = 1'b1;
            else REQ_J_ENABLE = 1'b1;
            @(negedge CLK);
            REQ_I_ENABLE = 1'b0;
            REQ_J_ENABLE = 1'b0;
            cnt = 1;
            if (r == int'(si) - 1 && c == int'(sj) - 1) begin
                chk("ready latency", READY, 1);
                if (noise) begin
                    START = 1'b1;
                    @(negedge CLK);
                    START = 1'b0;
                end
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("reset ready", READY, 0);
        chk("reset mem_re", MEM_RE, 0);
        chk("reset data_out", DATA_OUT, 0);
        chk("reset strobes", {DATA_I_ENABLE, DATA_J_ENABLE}, 0);
        RST = 1'b0;
        @(negedge CLK);
        run(2, 3, 64'h100, 0, 0, 0, 0, -1);
        run(0, 3, 64'h200, 0, 0, 0, 0, -1);
        run(2, 0, 64'h300, 0, 0, 0, 0, -1);
        run(2, 2, 64'h4000, 5, 5, 0, 0, -1);
        run(2, 3, 64'h500, 2, 3, 1, 0, -1);
        run(3, 3, 64'h600, 0, 2, 0, 0, 4);
        run(3, 3, 64'h600, 0, 2, 0, 0, -1);
        run(1, 4, 64'hFFFF_FFFF_FFFF_FFFE, 0, 3, 0, 1, -1);
        for (int t = 0; t < 10; t++) begin
            run(64'($urandom_range(4, 1)), 64'($urandom_range(4, 1)),
                {$urandom, $urandom}, 0, 3,
                1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), -1);
        end
        repeat (10) @(negedge CLK);
        chk("ready count", 64'(ready_exp), 0);
        chk("addr queue empty", 64'(exp_addr.size()), 0);
        chk("data queue empty", 64'(exp_data.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
